// File: rtl/priority_enc_pkg.sv
// Shared definitions for the registered priority encoder family.
// Provides the index-width helper and the arbitration mode enum.
package priority_enc_pkg;

  typedef enum logic {
    PRIO_FIXED = 1'b0,
    PRIO_RR    = 1'b1
  } prio_mode_e;

  // Index width for a request vector; never returns less than one bit.
  function automatic int unsigned idx_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/priority_enc_pick.sv
// Combinational cyclic-descending search for the first set request bit,
// starting at a given index and wrapping from 0 back to WIDTH-1.
module prio_pick
  import priority_enc_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDXW  = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  input  logic [IDXW-1:0]  start,
  output logic             found,
  output logic [IDXW-1:0]  idx
);

  localparam logic [IDXW-1:0] TOP_IDX = IDXW'(WIDTH - 1);

  logic [IDXW-1:0] pos;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = start;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      if (!found && req[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
      // Explicit wrap keeps non-power-of-two widths inside 0..WIDTH-1.
      pos = (pos == '0) ? TOP_IDX : pos - IDXW'(1);
    end
  end

endmodule

// File: rtl/priority_encoder_rr.sv
// Sticky request register with fixed-priority or round-robin selection
// and a valid/ready handshake that retires one index per grant.
module priority_encoder_rr
  import priority_enc_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned IDXW    = idx_width(WIDTH),
  parameter int unsigned RR_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_in,
  input  logic             clr,
  output logic [IDXW-1:0]  d_out,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] pending,
  output logic             ovf
);

  localparam prio_mode_e      MODE    = (RR_MODE != 0) ? PRIO_RR : PRIO_FIXED;
  localparam logic [IDXW-1:0] TOP_IDX = IDXW'(WIDTH - 1);

  logic [IDXW-1:0]  ptr;
  logic [IDXW-1:0]  ptr_next;
  logic [IDXW-1:0]  start;
  logic [IDXW-1:0]  pick_idx;
  logic             found;
  logic             grant;
  logic [WIDTH-1:0] grant_mask;
  logic [WIDTH-1:0] pending_next;
  logic             ovf_next;

  assign start = (MODE == PRIO_RR) ? ptr : TOP_IDX;

  prio_pick #(
    .WIDTH (WIDTH),
    .IDXW  (IDXW)
  ) u_pick (
    .req   (pending),
    .start (start),
    .found (found),
    .idx   (pick_idx)
  );

  // Selection, grant and next-state; set wins over grant-clear, clr wins over set.
  always_comb begin
    valid        = found;
    d_out        = found ? pick_idx : '0;
    grant        = found & ready;
    grant_mask   = grant ? (WIDTH'(1) << d_out) : '0;
    pending_next = (pending & ~grant_mask) | d_in;
    ovf_next     = ovf | (|(d_in & pending & ~grant_mask));
    ptr_next     = ptr;
    if (MODE == PRIO_RR && grant) begin
      ptr_next = (d_out == '0) ? TOP_IDX : d_out - IDXW'(1);
    end
    if (clr) begin
      pending_next = '0;
      ovf_next     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      ovf     <= 1'b0;
      ptr     <= TOP_IDX;
    end else begin
      pending <= pending_next;
      ovf     <= ovf_next;
      ptr     <= ptr_next;
    end
  end

endmodule

// File: tb/tb_priority_encoder_rr.sv
// Bench for priority_encoder_rr: fixed 8-bit, round-robin 8-bit and
// round-robin 5-bit instances against a behavioural arbitration model.
module tb_priority_encoder_rr;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] din  [N];
  logic       clr  [N];
  logic       rdy  [N];
  logic [2:0] o_dout [N];
  logic       o_val  [N];
  logic       o_ovf  [N];
  logic [7:0] o_pend [N];
  logic [7:0] pend0, pend1;
  logic [4:0] pend2;

  assign o_pend[0] = pend0;
  assign o_pend[1] = pend1;
  assign o_pend[2] = {3'b000, pend2};

  priority_encoder_rr #(.WIDTH(8), .RR_MODE(0)) u_fix8 (
    .clk(clk), .rst(rst), .d_in(din[0]), .clr(clr[0]), .d_out(o_dout[0]),
    .valid(o_val[0]), .ready(rdy[0]), .pending(pend0), .ovf(o_ovf[0]));

  priority_encoder_rr #(.WIDTH(8), .RR_MODE(1)) u_rr8 (
    .clk(clk), .rst(rst), .d_in(din[1]), .clr(clr[1]), .d_out(o_dout[1]),
    .valid(o_val[1]), .ready(rdy[1]), .pending(pend1), .ovf(o_ovf[1]));

  priority_encoder_rr #(.WIDTH(5), .RR_MODE(1)) u_rr5 (
    .clk(clk), .rst(rst), .d_in(din[2][4:0]), .clr(clr[2]), .d_out(o_dout[2]),
    .valid(o_val[2]), .ready(rdy[2]), .pending(pend2), .ovf(o_ovf[2]));

  // Reference model: pending as a bit set, pointer as a plain integer.
  int         w  [N] = '{8, 8, 5};
  bit         rr [N] = '{1'b0, 1'b1, 1'b1};
  logic [7:0] m_pend [N];
  int         m_ptr  [N];
  bit         m_ovf  [N];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] wmask(input int k);
    return 8'((1 << w[k]) - 1);
  endfunction

  // First set index scanning ptr, ptr-1, ... cyclically; -1 if nothing pending.
  function automatic int winner(input int k);
    for (int j = 0; j < w[k]; j++) begin
      int i;
      i = (m_ptr[k] - j + w[k]) % w[k];
      if (m_pend[k][i]) return i;
    end
    return -1;
  endfunction

  task automatic tick();
    logic [7:0] np [N];
    int         nptr [N];
    bit         novf [N];
    for (int k = 0; k < N; k++) begin
      int         wn;
      bit         g;
      logic [7:0] msk;
      logic [7:0] d;
      wn  = winner(k);
      g   = (wn >= 0) && rdy[k];
      msk = g ? 8'(1 << wn) : 8'h00;
      d   = din[k] & wmask(k);
      np[k]   = (m_pend[k] & ~msk) | d;
      novf[k] = m_ovf[k] | ((d & m_pend[k] & ~msk) != 8'h00);
      nptr[k] = m_ptr[k];
      if (rr[k] && g) nptr[k] = (wn == 0) ? w[k] - 1 : wn - 1;
      if (clr[k]) begin
        np[k]   = 8'h00;
        novf[k] = 1'b0;
      end
      if (rst) begin
        np[k]   = 8'h00;
        novf[k] = 1'b0;
        nptr[k] = w[k] - 1;
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      int wn;
      m_pend[k] = np[k];
      m_ovf[k]  = novf[k];
      m_ptr[k]  = nptr[k];
      wn = winner(k);
      check($sformatf("pend%0d", k), 64'(o_pend[k]), 64'(m_pend[k]));
      check($sformatf("valid%0d", k), 64'(o_val[k]), 64'(wn >= 0));
      check($sformatf("dout%0d", k), 64'(o_dout[k]), (wn >= 0) ? 64'(wn) : 64'd0);
      check($sformatf("ovf%0d", k), 64'(o_ovf[k]), 64'(m_ovf[k]));
    end
  endtask

  task automatic idle();
    for (int k = 0; k < N; k++) begin
      din[k] = 8'h00;
      clr[k] = 1'b0;
      rdy[k] = 1'b0;
    end
  endtask

  int exp_fix[3] = '{5, 2, 0};
  int exp_rr[6]  = '{7, 1, 0, 7, 1, 0};

  initial begin
    for (int k = 0; k < N; k++) begin
      m_pend[k] = 8'h00;
      m_ptr[k]  = w[k] - 1;
      m_ovf[k]  = 1'b0;
    end
    idle();
    rst = 1'b1;

    // Reset holds everything empty despite full requests.
    din[0] = 8'hFF; din[1] = 8'hFF; din[2] = 8'h1F;
    tick();
    tick();
    check("rst_valid", 64'(o_val[0]), 64'd0);
    check("rst_dout", 64'(o_dout[0]), 64'd0);
    rst = 1'b0;
    tick();
    check("rel_pend", 64'(o_pend[0]), 64'hFF);
    check("rel_dout", 64'(o_dout[0]), 64'd7);
    check("rel_dout5", 64'(o_dout[2]), 64'd4);

    idle();
    clr[0] = 1'b1; clr[1] = 1'b1; clr[2] = 1'b1;
    tick();
    idle();

    // Fixed-priority drain of a single pulse.
    din[0] = 8'hA5; rdy[0] = 1'b1;
    tick();
    check("drain_first", 64'(o_dout[0]), 64'd7);
    din[0] = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("drain_seq", 64'(o_dout[0]), 64'(exp_fix[i]));
    end
    tick();
    check("drain_empty", 64'(o_val[0]), 64'd0);

    // Round-robin fairness with a continuously held request pattern.
    idle();
    din[1] = 8'h83; rdy[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rr_seq", 64'(o_dout[1]), 64'(exp_rr[i]));
    end
    idle();
    clr[0] = 1'b1; clr[1] = 1'b1;
    tick();
    idle();

    // Set/clear collision on bit 3.
    din[0] = 8'h08;
    tick();
    rdy[0] = 1'b1;
    tick();
    check("coll_pend", 64'(o_pend[0]), 64'h08);
    check("coll_ovf0", 64'(o_ovf[0]), 64'd0);
    rdy[0] = 1'b0;
    tick();
    check("coll_ovf1", 64'(o_ovf[0]), 64'd1);
    idle();
    clr[0] = 1'b1;
    tick();
    check("clr_ovf", 64'(o_ovf[0]), 64'd0);

    // clr precedence with a simultaneous grant in RR mode.
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    din[1] = 8'h0F;
    tick();
    tick();
    check("clrp_dout", 64'(o_dout[1]), 64'd3);
    check("clrp_ovf", 64'(o_ovf[1]), 64'd1);
    din[1] = 8'h80; clr[1] = 1'b1; rdy[1] = 1'b1;
    tick();
    check("clrp_pend", 64'(o_pend[1]), 64'd0);
    check("clrp_ovfc", 64'(o_ovf[1]), 64'd0);
    idle();
    din[1] = 8'h0F;
    tick();
    check("clrp_ptr", 64'(o_dout[1]), 64'd2);

    // Five-wide round robin with pointer wrap.
    idle();
    din[2] = 8'h11;
    tick();
    check("w5_first", 64'(o_dout[2]), 64'd4);
    din[2] = 8'h00; rdy[2] = 1'b1;
    tick();
    check("w5_second", 64'(o_dout[2]), 64'd0);
    tick();
    check("w5_empty", 64'(o_val[2]), 64'd0);
    rdy[2] = 1'b0; din[2] = 8'h11;
    tick();
    check("w5_wrap", 64'(o_dout[2]), 64'd4);

    // Randomised traffic on all three instances.
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int k = 0; k < N; k++) begin
        din[k] = ($urandom_range(0, 2) == 0) ? 8'h00 : (8'($urandom) & 8'($urandom) & wmask(k));
        rdy[k] = ($urandom_range(0, 3) != 0);
        clr[k] = ($urandom_range(0, 49) == 0);
      end
      tick();
      check("w5_range", 64'(o_dout[2] < 3'd5), 64'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/priority_encoder_rr.md
# priority_encoder_rr

Parametrised, registered successor to the team's 8-bit combinational priority encoder. It latches incoming request bits into a sticky pending register and presents the index of the winning request with a valid/ready handshake. It selects in either fixed-priority mode (highest index wins) or round-robin mode, and clears each request bit once its index is accepted. It sits between request sources (interrupt lines, channel-ready flags) and a single consumer that services one index at a time.

## Interface
- WIDTH, 8: number of request lines; legal range 2..64, need not be a power of two.
- IDXW, $clog2(WIDTH): index width (derived; do not override).
- RR_MODE, 0: 0 = fixed priority (highest index wins); 1 = round-robin.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- d_in  input  WIDTH  request bits; each bit sampled every cycle and ORed into pending.
- clr  input  1  synchronous flush of pending and ovf.
- d_out  output  IDXW  index of current winner; 0 when valid=0.
- valid  output  1  at least one pending bit.
- ready  input  1  consumer accepts d_out this cycle.
- pending  output  WIDTH  pending register contents.
- ovf  output  1  sticky: a request arrived on an already-pending, not-granted bit.

## Operation
- Reset values: pending=0, valid=0, d_out=0, ovf=0, round-robin pointer ptr=WIDTH-1.
- valid = |pending. d_out is combinational from pending and ptr only, never from d_in. When valid=0, d_out is forced to 0; it is never X.
- Grant: grant = valid & ready. The granted bit is bit d_out.
- pending_next = (pending & ~(grant ? onehot(d_out) : 0)) | d_in.
- A new request on the bit being granted in the same cycle stays pending; set wins over clear.
- Fixed mode: the winner is the highest set index. The ptr register is unused and held at WIDTH-1.
- RR mode: the search starts at ptr and descends cyclically: ptr, ptr-1, ..., 0, WIDTH-1, ...
- RR pointer update: on grant of index g, ptr <= (g==0) ? WIDTH-1 : g-1, so g becomes lowest priority. Wrap uses an explicit compare, not modulo-2^IDXW.
- With ptr=WIDTH-1, RR selection is identical to fixed priority.
- ovf is set when d_in[i]=1 and pending[i]=1 and bit i is not being granted this cycle. It stays set until clr or rst.
- clr=1: next cycle pending=0 and ovf=0, and d_in that cycle is discarded. A grant in that cycle still counts and still advances ptr.
- rst dominates clr and everything else. A reset asserted mid-transfer discards all pending requests, and the consumer must treat the in-flight grant as not taken.

## Timing
- d_in bit set at edge N is visible on pending/valid/d_out after edge N; latency is 1 cycle.
- A grant at edge N clears the bit after edge N. The next winner is presented in the cycle after edge N, so back-to-back grants are possible at 1 per cycle.
- ready may be held high permanently. ready while valid=0 has no effect: no clear and no pointer move.
- d_out may change while valid=1 and ready=0 if a higher-priority request arrives. The consumer samples only on grant.

## Structure
- Shared package priority_enc_pkg: a constant function for index width, and a mode enum (PRIO_FIXED, PRIO_RR) mapped to RR_MODE.
- Sub-module prio_pick (combinational): inputs are the request vector and a start index; outputs are the found flag and index. Its search descends from start and wraps.
- The top level instantiates one prio_pick, with start tied to WIDTH-1 in fixed mode and to ptr in RR mode. The pending, ptr and ovf registers live in the top level.

## Test plan
- Reset: assert rst with d_in=8'hFF for 2 cycles -> pending=0, valid=0, d_out=0, ovf=0 throughout. Release -> the next cycle shows pending=8'hFF, valid=1, d_out=7.
- Fixed drain: pulse d_in=8'b1010_0101 for one cycle, hold ready=1 -> d_out sequence 7, 5, 2, 0 on consecutive cycles, then valid=0 and d_out=0.
- RR fairness (RR_MODE=1, WIDTH=8): hold d_in=8'b1000_0011 continuously with ready=1 -> grants 7, 1, 0, 7, 1, 0, ...; pointer wrap from 0 to 7 confirmed.
- Set/clear collision: pending bit 3 only, ready=1 with d_in bit 3 high the same cycle -> bit 3 still pending next cycle, ovf=0. With ready=0 -> ovf=1.
- clr precedence: pending=8'h0F, clr=1 with d_in=8'h80 and ready=1 -> pending=0 next cycle, ptr advanced past 3 in RR mode, ovf cleared.
- Non-power-of-2 width: WIDTH=5, RR_MODE=1, pending=5'b10001, grant 4 then 0 -> ptr goes 3, then wraps to 4. The index never reaches 5..7.
